ex_muldiv: RTL and testbench
============================

EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have clk  input  1  rising-edge clock.
REQ-002 SHALL have rst  input  1  reset; asynchronous, active-low.
REQ-003 SHALL have exception_flush  input  1  abort any operation in progress.
REQ-004 SHALL have start  input  1  request from EX for the instruction latched out of the ID2/EX register.
REQ-005 SHALL have op  input  2  operation: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
REQ-006 SHALL have src_a  input  32  rs data, as multiplicand or dividend.
REQ-007 SHALL have src_b  input  32  rt data, as multiplier or divisor.
REQ-008 SHALL have stall_req  output  1  holds the ID2/EX and earlier stages while high.
REQ-009 SHALL have done  output  1  single-cycle pulse; hi/lo valid.
REQ-010 SHALL have hi, lo  output  32 each  result registers.

Function
REQ-011 SHALL use FSM states IDLE, BUSY, FIX, DONE.
REQ-012 IDLE: start=1 SHALL capture |src_a|, |src_b|, both sign bits and op, clear iteration counter, and move to BUSY; start=0 keeps IDLE.
REQ-013 start SHALL be sampled only in IDLE; start in BUSY, FIX or DONE SHALL be ignored.
REQ-014 stall_req SHALL be (IDLE & start) | BUSY | FIX, combinational, so the requesting instruction is held from its first cycle.
REQ-015 BUSY SHALL do one radix-2 step per cycle: restoring divide for DIV/DIVU, shift-add multiply for MULT/MULTU; 6-bit counter; exit to FIX after the 32nd step.
REQ-016 Signed ops SHALL work on magnitudes; unsigned ops SHALL use raw operands. The magnitude of 32'h80000000 SHALL be 32'h80000000 taken as unsigned.
REQ-017 FIX SHALL apply signs. MULT: negate the 64-bit product when the operand signs differ. DIV: negate the quotient when the signs differ, and give the remainder the sign of the dividend. FIX SHALL then go to DONE.
REQ-018 Results: MULT/MULTU {hi,lo} = 64-bit product; DIV/DIVU lo = quotient, hi = remainder.
REQ-019 hi and lo SHALL update only on entry to DONE. DONE asserts done for exactly one cycle, then returns to IDLE.
REQ-020 Latency, iterative path: start in cycle 0; BUSY in cycles 1-32; FIX in cycle 33; done=1 in cycle 34; stall_req=1 in cycles 0-33 and 0 in cycle 34.
REQ-021 Divide by zero SHALL NOT trap. DIVU result: lo=32'hFFFFFFFF, hi=src_a. DIV result: the same unsigned result passed through the REQ-017 sign fix.
REQ-022 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL give lo=32'h80000000, hi=0.
REQ-023 exception_flush in any state SHALL force IDLE on the next edge. done SHALL stay 0 and hi/lo SHALL keep their previous values.
REQ-024 exception_flush and start in the same IDLE cycle: flush wins, nothing is captured, and stall_req SHALL be 0 that cycle.
REQ-025 hi/lo SHALL hold their value between operations.

Reset
REQ-026 rst low SHALL immediately force state=IDLE, counter=0, hi=0, lo=0, done=0 and all operand/partial registers to 0.
REQ-027 Reset asserted mid-operation SHALL abandon it, with no done pulse after release.
REQ-028 The first start SHALL be accepted in the first cycle after rst deasserts.

Configuration
REQ-029 Macro MULDIV_FAST_MUL_EN defined: MULT/MULTU SHALL compute the signed or unsigned 64-bit product in one cycle (IDLE to DONE directly), with done in cycle 1 and stall_req=1 in cycle 0 only. DIV/DIVU SHALL be unchanged.
REQ-030 Macro MULDIV_FAST_MUL_EN undefined: all ops SHALL use the iterative path with REQ-020 latency.

Structure
REQ-031 Shared package gemini_muldiv_pkg SHALL hold the op encodings, the FSM state encoding, DATA_W=32 and ITER_N=32.
REQ-032 One sub-module, muldiv_div_step, SHALL implement one combinational restoring-divide step (partial remainder, quotient shift) instantiated by ex_muldiv; all other logic SHALL be inline.

Verification
REQ-033 MULTU src_a=32'hFFFFFFFF, src_b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001; done in cycle 34, or in cycle 1 with MULDIV_FAST_MUL_EN.
REQ-034 MULT src_a=-7 (32'hFFFFFFF9), src_b=3 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB; stall_req high in cycles 0-33.
REQ-035 DIV src_a=-7, src_b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. DIVU 100/7 -> lo=14, hi=2.
REQ-036 DIVU src_a=32'h12345678, src_b=0 -> lo=32'hFFFFFFFF, hi=32'h12345678. DIV 32'h80000000/32'hFFFFFFFF -> lo=32'h80000000, hi=0.
REQ-037 Start DIVU, assert exception_flush in cycle 10 -> IDLE in cycle 11, no done, hi/lo unchanged; a new start in cycle 11 completes normally.
REQ-038 Drop rst low in cycle 15 of a DIV -> outputs immediately 0; start held high during reset is ignored; first accepted start follows the first edge after release.

Source files
------------

// File: rtl/gemini_muldiv_pkg.sv
// -----------------------------------------------------------------------------
// gemini_muldiv_pkg
// Shared definitions for the EX-stage multiply/divide unit: operation codes,
// FSM state encoding, datapath widths and small operand helpers.
// -----------------------------------------------------------------------------
package gemini_muldiv_pkg;

  localparam int DATA_W = 32;
  localparam int ITER_N = 32;
  localparam int CNT_W  = 6;

  localparam logic [CNT_W-1:0] CNT_ZERO = 6'd0;
  localparam logic [CNT_W-1:0] CNT_ONE  = 6'd1;
  // Counter value during the final radix-2 step
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_N - 1);

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  // Magnitude for signed ops; 32'h80000000 maps to itself, read as unsigned.
  function automatic logic [DATA_W-1:0] op_magnitude(input logic [DATA_W-1:0] v,
                                                     input logic use_sign);
    return (use_sign && v[DATA_W-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// -----------------------------------------------------------------------------
// muldiv_div_step
// One combinational restoring-divide step: shift the next dividend bit into
// the partial remainder, trial-subtract the divisor, and shift the resulting
// quotient bit into the low end of the dividend/quotient word.
// Ports:
//   rem      - current partial remainder
//   quo      - dividend bits not yet consumed (MSB next) / quotient so far
//   divisor  - divisor magnitude
//   rem_next - updated partial remainder
//   quo_next - quo shifted left with the new quotient bit
// -----------------------------------------------------------------------------
module muldiv_div_step
  import gemini_muldiv_pkg::*;
(
  input  logic [DATA_W-1:0] rem,
  input  logic [DATA_W-1:0] quo,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_next,
  output logic [DATA_W-1:0] quo_next
);

  logic [DATA_W:0]   shifted_s;
  logic [DATA_W-1:0] diff_s;

  // Trial subtraction; when it fits, the true difference is below 2^32 so the
  // low word of the modular difference is exact.
  always_comb begin
    shifted_s = {rem, quo[DATA_W-1]};
    diff_s    = shifted_s[DATA_W-1:0] - divisor;
    if (shifted_s >= {1'b0, divisor}) begin
      rem_next = diff_s;
      quo_next = {quo[DATA_W-2:0], 1'b1};
    end else begin
      rem_next = shifted_s[DATA_W-1:0];
      quo_next = {quo[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// -----------------------------------------------------------------------------
// ex_muldiv
// EX-stage multiply/divide unit for MULT, MULTU, DIV and DIVU. Iterative
// radix-2 datapath (shift-add multiply, restoring divide) with signs applied
// in a final FIX cycle. hi/lo are written only when entering DONE.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies complete in a single
// cycle (IDLE straight to DONE); divides keep the iterative path.
// Ports:
//   clk             - rising-edge clock
//   rst             - asynchronous active-low reset
//   exception_flush - abort any operation in progress
//   start           - operation request (sampled in IDLE only)
//   op              - 0=MULT 1=MULTU 2=DIV 3=DIVU
//   src_a, src_b    - multiplicand/dividend, multiplier/divisor
//   stall_req       - hold ID2/EX and earlier stages
//   done            - one-cycle pulse, hi/lo valid
//   hi, lo          - result registers
// -----------------------------------------------------------------------------
module ex_muldiv
  import gemini_muldiv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              exception_flush,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic              stall_req,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  state_e              state_r;
  state_e              state_n_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [1:0]          op_r;
  logic                sign_a_r;
  logic                sign_b_r;
  logic [DATA_W-1:0]   b_r;
  // Multiply: {accumulator, multiplier}. Divide: {remainder, dividend/quotient}.
  logic [2*DATA_W-1:0] p_r;
  logic [2*DATA_W-1:0] p_step_s;
  logic [DATA_W:0]     mul_sum_s;
  logic [DATA_W-1:0]   rem_step_s;
  logic [DATA_W-1:0]   quo_step_s;
  logic [2*DATA_W-1:0] prod_fix_s;
  logic [DATA_W-1:0]   quo_fix_s;
  logic [DATA_W-1:0]   rem_fix_s;
  logic [DATA_W-1:0]   hi_n_s;
  logic [DATA_W-1:0]   lo_n_s;
  logic                load_res_s;
  logic                stall_s;
  logic [DATA_W-1:0]   hi_r;
  logic [DATA_W-1:0]   lo_r;
  logic                done_r;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*DATA_W-1:0] fast_prod_s;
  logic                fast_sa_s;
  logic                fast_sb_s;

  // Single-cycle product from the raw request operands
  always_comb begin
    fast_sa_s   = src_a[DATA_W-1] & op_is_signed(op);
    fast_sb_s   = src_b[DATA_W-1] & op_is_signed(op);
    fast_prod_s = {{DATA_W{fast_sa_s}}, src_a} * {{DATA_W{fast_sb_s}}, src_b};
  end
`endif

  muldiv_div_step u_div_step (
    .rem      (p_r[2*DATA_W-1:DATA_W]),
    .quo      (p_r[DATA_W-1:0]),
    .divisor  (b_r),
    .rem_next (rem_step_s),
    .quo_next (quo_step_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // FSM next-state logic; flush overrides everything
  always_comb begin
    state_n_s = state_r;
    if (exception_flush) begin
      state_n_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
`ifdef MULDIV_FAST_MUL_EN
            if (op_is_div(op)) begin
              state_n_s = ST_BUSY;
            end else begin
              state_n_s = ST_DONE;
            end
`else
            state_n_s = ST_BUSY;
`endif
          end else begin
            state_n_s = ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (cnt_r == CNT_LAST) begin
            state_n_s = ST_FIX;
          end else begin
            state_n_s = ST_BUSY;
          end
        end
        ST_FIX:  state_n_s = ST_DONE;
        ST_DONE: state_n_s = ST_IDLE;
        default: state_n_s = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: stall from the request cycle until FIX; nothing while in reset
  always_comb begin
    case (state_r)
      ST_IDLE: stall_s = start & ~exception_flush;
      ST_BUSY: stall_s = 1'b1;
      ST_FIX:  stall_s = 1'b1;
      default: stall_s = 1'b0;
    endcase
    stall_req  = rst & stall_s;
    load_res_s = (state_n_s == ST_DONE);
  end

  // One radix-2 iteration of whichever algorithm the captured op selects
  always_comb begin
    mul_sum_s = {1'b0, p_r[2*DATA_W-1:DATA_W]} +
                (p_r[0] ? {1'b0, b_r} : {(DATA_W+1){1'b0}});
    if (op_is_div(op_r)) begin
      p_step_s = {rem_step_s, quo_step_s};
    end else begin
      p_step_s = {mul_sum_s, p_r[DATA_W-1:1]};
    end
  end

  // Sign correction: product/quotient negated on differing signs,
  // remainder follows the dividend
  always_comb begin
    if (op_is_signed(op_r) && (sign_a_r ^ sign_b_r)) begin
      prod_fix_s = -p_r;
      quo_fix_s  = -p_r[DATA_W-1:0];
    end else begin
      prod_fix_s = p_r;
      quo_fix_s  = p_r[DATA_W-1:0];
    end
    if (op_is_signed(op_r) && sign_a_r) begin
      rem_fix_s = -p_r[2*DATA_W-1:DATA_W];
    end else begin
      rem_fix_s = p_r[2*DATA_W-1:DATA_W];
    end
  end

  // Value loaded into hi/lo on entry to DONE
  always_comb begin
    hi_n_s = hi_r;
    lo_n_s = lo_r;
`ifdef MULDIV_FAST_MUL_EN
    if (state_r == ST_IDLE) begin
      {hi_n_s, lo_n_s} = fast_prod_s;
    end else if (op_is_div(op_r)) begin
      hi_n_s = rem_fix_s;
      lo_n_s = quo_fix_s;
    end else begin
      {hi_n_s, lo_n_s} = prod_fix_s;
    end
`else
    if (op_is_div(op_r)) begin
      hi_n_s = rem_fix_s;
      lo_n_s = quo_fix_s;
    end else begin
      {hi_n_s, lo_n_s} = prod_fix_s;
    end
`endif
  end

  // Operand capture in IDLE and iteration in BUSY
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r    <= CNT_ZERO;
      op_r     <= 2'd0;
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      b_r      <= {DATA_W{1'b0}};
      p_r      <= {(2*DATA_W){1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && !exception_flush) begin
            op_r     <= op;
            sign_a_r <= src_a[DATA_W-1];
            sign_b_r <= src_b[DATA_W-1];
            b_r      <= op_magnitude(src_b, op_is_signed(op));
            p_r      <= {{DATA_W{1'b0}}, op_magnitude(src_a, op_is_signed(op))};
            cnt_r    <= CNT_ZERO;
          end
        end
        ST_BUSY: begin
          p_r   <= p_step_s;
          cnt_r <= cnt_r + CNT_ONE;
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Result registers and done pulse, written only when entering DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_r   <= {DATA_W{1'b0}};
      lo_r   <= {DATA_W{1'b0}};
      done_r <= 1'b0;
    end else begin
      done_r <= load_res_s;
      if (load_res_s) begin
        hi_r <= hi_n_s;
        lo_r <= lo_n_s;
      end
    end
  end

  assign hi   = hi_r;
  assign lo   = lo_r;
  assign done = done_r;

endmodule

// File: tb/tb_ex_muldiv.sv
// -----------------------------------------------------------------------------
// tb_ex_muldiv
// Self-checking bench for ex_muldiv: directed vector table, flush and reset
// sequences, and randomized operations against a plain-arithmetic model.
// -----------------------------------------------------------------------------
module tb_ex_muldiv;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;

  logic        clk = 1'b0;
  logic        rst;
  logic        exception_flush;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        stall_req;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;

  ex_muldiv dut (
    .clk             (clk),
    .rst             (rst),
    .exception_flush (exception_flush),
    .start           (start),
    .op              (op),
    .src_a           (src_a),
    .src_b           (src_b),
    .stall_req       (stall_req),
    .done            (done),
    .hi              (hi),
    .lo              (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: {hi, lo} from integer arithmetic on the architectural rules.
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: p = 64'(sa * sb);
      2'd1: p = {32'h0, a} * {32'h0, b};
      2'd2: begin
        if (b == 32'h0) begin
          // unsigned result (q=all ones, r=|a|), then signs: q negated when a<0, r takes a's sign
          p = {a, (a[31] ? 32'h00000001 : 32'hFFFFFFFF)};
        end else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'h0) p = {a, 32'hFFFFFFFF};
        else            p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  // Follow an operation whose start is being driven in the current cycle (cycle 0).
  task automatic wait_done(input bit keep, input int exp_lat, input logic [31:0] eh,
                           input logic [31:0] el, input string tag);
    int lat;
    bit stall_ok;
    bit hold_ok;
    lat      = -1;
    stall_ok = 1'b1;
    hold_ok  = 1'b1;
    for (int c = 0; c <= 60; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (!keep) start = 1'b0;
        if (c == 1) begin
          src_a = ~src_a;
          src_b = src_b ^ 32'h5A5A5A5A;
        end
      end
      @(negedge clk);
      if (done === 1'b1) begin
        lat = c;
        if (stall_req !== 1'b0) stall_ok = 1'b0;
        break;
      end
      if (stall_req !== 1'b1) stall_ok = 1'b0;
      if (hi !== m_hi || lo !== m_lo) hold_ok = 1'b0;
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " stall_req"}, 64'(stall_ok), 64'd1);
    chk({tag, " hold"}, 64'(hold_ok), 64'd1);
    chk({tag, " hi"}, 64'(hi), 64'(eh));
    chk({tag, " lo"}, 64'(lo), 64'(el));
    m_hi = eh;
    m_lo = el;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk({tag, " done one-shot"}, 64'(done), 64'd0);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input bit keep,
                        input string tag);
    @(posedge clk); #1;
    exception_flush = 1'b0;
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    wait_done(keep, o[1] ? DIV_LAT : MUL_LAT, eh, el, tag);
  endtask

  initial begin
    logic [63:0] e;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    bit          fl_ok;

    vecs[0] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{2'd0, 32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2] = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{2'd3, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[4] = '{2'd3, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
    vecs[5] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[6] = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[7] = '{2'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8] = '{2'd2, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'h00000001};
    vecs[9] = '{2'd1, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000};

    rst = 1'b0;
    exception_flush = 1'b0;
    start = 1'b0;
    op    = 2'd0;
    src_a = 32'h0;
    src_b = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset stall_req", 64'(stall_req), 64'd0);
    rst = 1'b1;

    // Directed table (first entry starts in the first cycle after release)
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 1'b0,
             $sformatf("vec%0d", i));
    end

    // Flush in cycle 10 of a DIVU, new start in cycle 11
    @(posedge clk); #1;
    exception_flush = 1'b0;
    start = 1'b1;
    op    = 2'd3;
    src_a = 32'd1000;
    src_b = 32'd3;
    fl_ok = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || hi !== m_hi || lo !== m_lo) fl_ok = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      if (c == 10) exception_flush = 1'b1;
    end
    @(negedge clk);
    if (done !== 1'b0 || hi !== m_hi || lo !== m_lo) fl_ok = 1'b0;
    chk("flush no done, hi/lo held", 64'(fl_ok), 64'd1);
    run_op(2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "after flush");

    // Flush and start in the same IDLE cycle: nothing captured
    @(posedge clk); #1;
    start = 1'b1;
    exception_flush = 1'b1;
    op    = 2'd2;
    src_a = 32'd50;
    src_b = 32'd5;
    @(negedge clk);
    chk("flush+start stall_req", 64'(stall_req), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    exception_flush = 1'b0;
    @(negedge clk);
    chk("flush+start still idle", 64'(stall_req), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("flush+start no done", 64'(done), 64'd0);

    // Randomized operations against the model
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: ra = 32'h80000000;
        2: rb = $urandom_range(1, 15);
        3: rb = 32'hFFFFFFFF;
        default: ;
      endcase
      e = ref_model(ro, ra, rb);
      run_op(ro, ra, rb, e[63:32], e[31:0], ($urandom_range(0, 3) == 0),
             $sformatf("rand%0d op%0d", i, ro));
    end

    // Known nonzero result before the mid-operation reset
    run_op(2'd1, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, "pre-reset");

    // Reset dropped in cycle 15 of a DIV, start held high throughout
    @(posedge clk); #1;
    start = 1'b1;
    op    = 2'd2;
    src_a = 32'hFFFFFF00;
    src_b = 32'd7;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    chk("mid-op reset hi", 64'(hi), 64'd0);
    chk("mid-op reset lo", 64'(lo), 64'd0);
    chk("mid-op reset done", 64'(done), 64'd0);
    chk("mid-op reset stall_req", 64'(stall_req), 64'd0);
    m_hi = 32'h0;
    m_lo = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("in reset done", 64'(done), 64'd0);
    chk("in reset stall_req", 64'(stall_req), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    src_a = 32'hFFFFFF00;
    src_b = 32'd7;
    e = ref_model(2'd2, 32'hFFFFFF00, 32'd7);
    wait_done(1'b0, DIV_LAT, e[63:32], e[31:0], "after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
